// File: rtl/register_file_if.sv
// Register-file access bundle: two read ports and one write port.
// The master drives addresses and write data; the slave returns read data.
interface register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] read_address_0;
    logic [ADDR_WIDTH-1:0] read_address_1;
    logic [ADDR_WIDTH-1:0] write_address_0;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data_0;
    logic [DATA_WIDTH-1:0] read_data_1;

    modport master (
        output read_address_0,
        output read_address_1,
        output write_address_0,
        output write_en,
        output write_data,
        input  read_data_0,
        input  read_data_1
    );

    modport slave (
        input  read_address_0,
        input  read_address_1,
        input  write_address_0,
        input  write_en,
        input  write_data,
        output read_data_0,
        output read_data_1
    );
endinterface

// File: rtl/register_file.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file, two combinational reads, one synchronous write, r0 reads zero.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to a matching read port.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic           clk,
    input  logic           rst,
    register_file_if.slave s_rf
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
    logic                  w_wr_valid;
    logic [DATA_WIDTH-1:0] w_rd0;
    logic [DATA_WIDTH-1:0] w_rd1;

    // A write is qualified only when not in reset and not targeting r0.
    assign w_wr_valid = s_rf.write_en && !rst
                        && (s_rf.write_address_0 != {ADDR_WIDTH{1'b0}});

    // Storage update: reset clears everything and discards any concurrent write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (w_wr_valid) begin
            r_mem[s_rf.write_address_0] <= s_rf.write_data;
        end
    end

    // Read port 0: r0 is forced to zero regardless of what the array holds.
    always_comb begin
        w_rd0 = {DATA_WIDTH{1'b0}};
        if (s_rf.read_address_0 == {ADDR_WIDTH{1'b0}}) begin
            w_rd0 = {DATA_WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
        end else if (w_wr_valid && (s_rf.read_address_0 == s_rf.write_address_0)) begin
            w_rd0 = s_rf.write_data;
`endif
        end else begin
            w_rd0 = r_mem[s_rf.read_address_0];
        end
    end

    // Read port 1: identical to port 0, fully independent addressing.
    always_comb begin
        w_rd1 = {DATA_WIDTH{1'b0}};
        if (s_rf.read_address_1 == {ADDR_WIDTH{1'b0}}) begin
            w_rd1 = {DATA_WIDTH{1'b0}};
`ifdef REGFILE_BYPASS_EN
        end else if (w_wr_valid && (s_rf.read_address_1 == s_rf.write_address_0)) begin
            w_rd1 = s_rf.write_data;
`endif
        end else begin
            w_rd1 = r_mem[s_rf.read_address_1];
        end
    end

    assign s_rf.read_data_0 = w_rd0;
    assign s_rf.read_data_1 = w_rd1;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file; expected values are hand-computed constants
// plus a shadow array for the bulk write/readback sweep.
module tb_register_file;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk;
    logic rst;
    int   checks_cnt;
    int   errors_cnt;
    logic [DW-1:0] shadow [32];

    register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_if ();

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .s_rf (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic set_reads(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        u_if.read_address_0 = a0;
        u_if.read_address_1 = a1;
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(negedge clk);
        u_if.write_address_0 = addr;
        u_if.write_data      = data;
        u_if.write_en        = 1'b1;
        @(negedge clk);
        u_if.write_en        = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst = 1'b1;
        u_if.read_address_0  = 5'd0;
        u_if.read_address_1  = 5'd31;
        u_if.write_address_0 = 5'd0;
        u_if.write_en        = 1'b0;
        u_if.write_data      = 32'h0000_0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        set_reads(5'd0, 5'd31);
        check_value("reset_r0", u_if.read_data_0, 32'h0000_0000);
        check_value("reset_r31", u_if.read_data_1, 32'h0000_0000);

        write_reg(5'd1, 32'hA5A5_A5A5);
        set_reads(5'd1, 5'd2);
        check_value("wr1_r1", u_if.read_data_0, 32'hA5A5_A5A5);
        check_value("wr1_r2", u_if.read_data_1, 32'h0000_0000);

        write_reg(5'd2, 32'h5A5A_5A5A);
        set_reads(5'd1, 5'd2);
        check_value("wr2_r1", u_if.read_data_0, 32'hA5A5_A5A5);
        check_value("wr2_r2", u_if.read_data_1, 32'h5A5A_5A5A);
        set_reads(5'd2, 5'd1);
        check_value("swap_p0", u_if.read_data_0, 32'h5A5A_5A5A);
        check_value("swap_p1", u_if.read_data_1, 32'hA5A5_A5A5);

        write_reg(5'd0, 32'hFFFF_FFFF);
        set_reads(5'd0, 5'd1);
        check_value("r0_prot", u_if.read_data_0, 32'h0000_0000);
        check_value("r0_r1_kept", u_if.read_data_1, 32'hA5A5_A5A5);

        // write_en low: nothing may change, and no forwarding either
        @(negedge clk);
        u_if.write_address_0 = 5'd3;
        u_if.write_data      = 32'h1234_5678;
        u_if.write_en        = 1'b0;
        set_reads(5'd3, 5'd3);
        check_value("we0_pre", u_if.read_data_0, 32'h0000_0000);
        @(negedge clk);
        set_reads(5'd3, 5'd2);
        check_value("we0_r3", u_if.read_data_0, 32'h0000_0000);
        check_value("we0_r2", u_if.read_data_1, 32'h5A5A_5A5A);

        // Fill every register and read back all of them on both ports
        shadow[0] = 32'h0000_0000;
        for (int i = 1; i < 32; i++) begin
            shadow[i] = 32'hC000_0000 ^ (32'(i) * 32'h0101_0101);
            write_reg(AW'(i), shadow[i]);
        end
        for (int i = 0; i < 32; i++) begin
            set_reads(AW'(i), AW'(31 - i));
            check_value($sformatf("sweep_p0_%0d", i), u_if.read_data_0, shadow[i]);
            check_value($sformatf("sweep_p1_%0d", 31 - i), u_if.read_data_1, shadow[31 - i]);
        end

        // Reset with a simultaneous write: the write must be discarded
        @(negedge clk);
        rst = 1'b1;
        u_if.write_address_0 = 5'd7;
        u_if.write_data      = 32'hDEAD_BEEF;
        u_if.write_en        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        u_if.write_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            set_reads(AW'(i), AW'(31 - i));
            check_value($sformatf("rstprio_p0_%0d", i), u_if.read_data_0, 32'h0000_0000);
            check_value($sformatf("rstprio_p1_%0d", 31 - i), u_if.read_data_1, 32'h0000_0000);
        end

        // Read-during-write on r5
        write_reg(5'd5, 32'h1111_1111);
        @(negedge clk);
        u_if.write_address_0 = 5'd5;
        u_if.write_data      = 32'h2222_2222;
        u_if.write_en        = 1'b1;
        set_reads(5'd5, 5'd4);
`ifdef REGFILE_BYPASS_EN
        check_value("rdw_pre_edge", u_if.read_data_0, 32'h2222_2222);
`else
        check_value("rdw_pre_edge", u_if.read_data_0, 32'h1111_1111);
`endif
        check_value("rdw_other", u_if.read_data_1, 32'h0000_0000);
        @(posedge clk);
        #1;
        check_value("rdw_post_edge", u_if.read_data_0, 32'h2222_2222);
        @(negedge clk);
        u_if.write_en = 1'b0;
        set_reads(5'd4, 5'd5);
        check_value("rdw_stored", u_if.read_data_1, 32'h2222_2222);

        // Write to r0 in flight: never forwarded
        @(negedge clk);
        u_if.write_address_0 = 5'd0;
        u_if.write_data      = 32'hFFFF_FFFF;
        u_if.write_en        = 1'b1;
        set_reads(5'd0, 5'd5);
        check_value("r0_nobypass", u_if.read_data_0, 32'h0000_0000);
        check_value("r0_nobypass_r5", u_if.read_data_1, 32'h2222_2222);
        @(negedge clk);
        u_if.write_en = 1'b0;
        set_reads(5'd0, 5'd0);
        check_value("r0_after", u_if.read_data_0, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
